// File: rtl/serial_sub_if.sv
// Handshake and operand/result bundle for serial_sub.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, borrow_out
`ifdef SERIAL_SUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, borrow_out
`ifdef SERIAL_SUB_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor: one full-subtractor cell sequenced LSB first.
// Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
module fs (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ cin;
    assign bout = (~a & b) | (~(a ^ b) & cin);
endmodule

module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    serial_sub_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_r;
    logic [1:0]       state_nx_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [WIDTH-1:0] res_r;
    logic             brw_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_out_r;
    logic             fs_d_s;
    logic             fs_b_s;
    logic             last_bit_s;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_r;
    logic             b_msb_r;
    logic             ovf_r;
`endif

    fs u_fs (
        .a    (sa_r[0]),
        .b    (sb_r[0]),
        .cin  (brw_r),
        .d    (fs_d_s),
        .bout (fs_b_s)
    );

    assign last_bit_s = (state_r == RUN) && (cnt_r == LAST_CNT);

    // Next-state decode; start only matters in IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) state_nx_s = RUN;
                else           state_nx_s = IDLE;
            end
            RUN: begin
                if (last_bit_s) state_nx_s = DONE;
                else            state_nx_s = RUN;
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Sequencer, datapath shift registers and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= {CW{1'b0}};
            sa_r         <= {WIDTH{1'b0}};
            sb_r         <= {WIDTH{1'b0}};
            res_r        <= {WIDTH{1'b0}};
            brw_r        <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            diff_r       <= {WIDTH{1'b0}};
            borrow_out_r <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_r      <= 1'b0;
            b_msb_r      <= 1'b0;
            ovf_r        <= 1'b0;
`endif
        end else begin
            state_r <= state_nx_s;
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        sa_r   <= bus.a;
                        sb_r   <= bus.b;
                        brw_r  <= bus.bin;
                        cnt_r  <= {CW{1'b0}};
                        busy_r <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                        // Operand sign bits are kept since sa/sb shift them out.
                        a_msb_r <= bus.a[WIDTH-1];
                        b_msb_r <= bus.b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    res_r <= {fs_d_s, res_r[WIDTH-1:1]};
                    sa_r  <= {1'b0, sa_r[WIDTH-1:1]};
                    sb_r  <= {1'b0, sb_r[WIDTH-1:1]};
                    brw_r <= fs_b_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (last_bit_s) begin
                        busy_r       <= 1'b0;
                        done_r       <= 1'b1;
                        diff_r       <= {fs_d_s, res_r[WIDTH-1:1]};
                        borrow_out_r <= fs_b_s;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_r <= (a_msb_r != b_msb_r) && (fs_d_s != a_msb_r);
`endif
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.diff       = diff_r;
    assign bus.borrow_out = borrow_out_r;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf        = ovf_r;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=8) with a result scoreboard.
// Checks ovf as well when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bo;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [W-1:0] last_diff = 8'h00;

    serial_sub_if #(.WIDTH(W)) dut_if ();
    serial_sub #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(dut_if.slave));

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        exp_t e;
        logic [W:0] full;
        full   = {1'b0, a} - {1'b0, b} - {8'd0, bi};
        e.diff = full[W-1:0];
        e.bo   = full[W];
        e.ovf  = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    // Scoreboard consumer and busy/done exclusivity monitor.
    always @(negedge clk) begin
        if (dut_if.busy && dut_if.done) begin
            checks++; errors++;
            $display("FAIL busy_done_overlap: busy=%b done=%b, required not both", dut_if.busy, dut_if.done);
        end
        if (dut_if.done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: diff=%h with empty scoreboard", dut_if.diff);
            end else begin
                mon_e = sb.pop_front();
                last_diff = mon_e.diff;
                if (dut_if.diff !== mon_e.diff || dut_if.borrow_out !== mon_e.bo) begin
                    errors++;
                    $display("FAIL result: diff=%h borrow=%b, required diff=%h borrow=%b",
                             dut_if.diff, dut_if.borrow_out, mon_e.diff, mon_e.bo);
                end
`ifdef SERIAL_SUB_OVF_EN
                checks++;
                if (dut_if.ovf !== mon_e.ovf) begin
                    errors++;
                    $display("FAIL ovf: got %b, required %b", dut_if.ovf, mon_e.ovf);
                end
`endif
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while ((dut_if.busy || dut_if.done) && t < 40) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        int busy_cnt = 0;
        int t = 0;
        logic hold_bad = 1'b0;
        logic [W-1:0] held;
        wait_idle();
        held = last_diff;
        dut_if.a = a; dut_if.b = b; dut_if.bin = bi; dut_if.start = 1'b1;
        sb.push_back(model(a, b, bi));
        @(posedge clk); #1;
        dut_if.start = 1'b0;
        while (!dut_if.done && t < 40) begin
            @(negedge clk);
            if (dut_if.busy) begin
                busy_cnt++;
                if (dut_if.diff !== held) hold_bad = 1'b1;
            end
            t++;
        end
        checks++;
        if (!dut_if.done) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles for a=%h b=%h", t, a, b);
        end
        checks++;
        if (busy_cnt !== W) begin
            errors++;
            $display("FAIL busy_len: got %0d cycles, required %0d", busy_cnt, W);
        end
        checks++;
        if (hold_bad) begin
            errors++;
            $display("FAIL diff_hold: diff changed during RUN, required %h", held);
        end
        @(negedge clk);
        checks++;
        if (dut_if.done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b one cycle later, required 0", dut_if.done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut_if.busy !== 1'b0 || dut_if.done !== 1'b0 || dut_if.diff !== 8'h00 || dut_if.borrow_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b diff=%h borrow=%b, required all 0",
                     dut_if.busy, dut_if.done, dut_if.diff, dut_if.borrow_out);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (dut_if.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b, required 0", dut_if.ovf);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_subtract();
        do_op(8'h05, 8'h03, 1'b0);
        do_op(8'h03, 8'h05, 1'b0);
        do_op(8'h00, 8'h00, 1'b1);
        do_op(8'hFF, 8'hFF, 1'b0);
        do_op(8'h80, 8'h01, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0);
        do_op(8'h01, 8'h80, 1'b0);
        do_op(8'h00, 8'hFF, 1'b1);
    endtask

    task automatic test_back_to_back();
        int done_at[$];
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rbin;
        wait_idle();
        ra = 8'h9C; rb = 8'h2D; rbin = 1'b1;
        dut_if.a = ra; dut_if.b = rb; dut_if.bin = rbin; dut_if.start = 1'b1;
        sb.push_back(model(ra, rb, rbin));
        for (int p = 0; p < 34; p++) begin
            @(posedge clk); #1;
            if (dut_if.done) done_at.push_back(p);
            if (p == 20) dut_if.start = 1'b0;
            ra = 8'($urandom_range(255, 0));
            rb = 8'($urandom_range(255, 0));
            rbin = 1'($urandom_range(1, 0));
            dut_if.a = ra; dut_if.b = rb; dut_if.bin = rbin;
            // Operands presented here are sampled at edge p+1; only IDLE edges accept.
            if (p < 20 && ((p + 1) % 10) == 0) sb.push_back(model(ra, rb, rbin));
        end
        checks++;
        if (done_at.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d done pulses, required 3", done_at.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (done_at[i] - done_at[i-1] != W + 2) begin
                    errors++;
                    $display("FAIL b2b_spacing: got %0d cycles, required %0d", done_at[i] - done_at[i-1], W + 2);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        wait_idle();
        dut_if.a = 8'hA5; dut_if.b = 8'h3C; dut_if.bin = 1'b0; dut_if.start = 1'b1;
        @(posedge clk); #1;
        dut_if.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        last_diff = 8'h00;
        checks++;
        if (dut_if.busy !== 1'b0 || dut_if.done !== 1'b0 || dut_if.diff !== 8'h00 || dut_if.borrow_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b diff=%h borrow=%b, required all 0",
                     dut_if.busy, dut_if.done, dut_if.diff, dut_if.borrow_out);
        end
        repeat (12) @(posedge clk);
        do_op(8'h10, 8'h01, 1'b0);
    endtask

    initial begin
        dut_if.start = 1'b0;
        dut_if.a = 8'h00;
        dut_if.b = 8'h00;
        dut_if.bin = 1'b0;
        test_reset();
        test_subtract();
        test_back_to_back();
        do_op(8'h55, 8'h2A, 1'b0);
        test_reset_mid();
        repeat (4) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
